// File: rtl/regwrite_arbiter.sv
// Register-file write-port arbiter for ALU and load writebacks, with a pending-write scoreboard.
// Define REGWR_AGE_EN to let a starved ALU request override memory priority.
module regwrite_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_addr,
  input  logic [63:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [4:0]  mem_addr,
  input  logic [63:0] mem_data,
  output logic        mem_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_addr,
  input  logic [4:0]  chk_addr1,
  input  logic [4:0]  chk_addr2,
  output logic        chk_busy1,
  output logic        chk_busy2,
  output logic        rf_wr_en,
  output logic [4:0]  rf_wr_addr,
  output logic [63:0] rf_wr_data
);

  localparam logic [4:0] XZR = 5'd31;

  logic        override;
  logic        alu_fire;
  logic        mem_fire;
  logic        xfer;
  logic [4:0]  xfer_addr;
  logic [63:0] xfer_data;
  logic [31:0] scoreboard;
  logic [31:0] scoreboard_next;

`ifdef REGWR_AGE_EN
  logic [1:0] age;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      age <= 2'd0;
    end else if (!alu_valid || alu_fire) begin
      age <= 2'd0;
    end else if (age != 2'd3) begin
      age <= age + 2'd1;
    end
  end

  assign override = alu_valid && (age == 2'd3);
`else
  assign override = 1'b0;
`endif

  // Ready is gated by reset so nothing can be accepted while reset is held.
  always_comb begin
    mem_ready = 1'b0;
    alu_ready = 1'b0;
    if (reset_n) begin
      mem_ready = !override;
      alu_ready = !mem_valid || override;
    end
  end

  always_comb begin
    mem_fire  = mem_valid && mem_ready;
    alu_fire  = alu_valid && alu_ready;
    xfer      = mem_fire || alu_fire;
    xfer_addr = alu_addr;
    xfer_data = alu_data;
    if (mem_fire) begin
      xfer_addr = mem_addr;
      xfer_data = mem_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_wr_en   <= 1'b0;
      rf_wr_addr <= 5'd0;
      rf_wr_data <= 64'd0;
    end else begin
      rf_wr_en <= xfer && (xfer_addr != XZR);
      if (xfer) begin
        rf_wr_addr <= xfer_addr;
        rf_wr_data <= xfer_data;
      end
    end
  end

  // Clear is applied before set so a same-edge issue keeps the register pending.
  always_comb begin
    scoreboard_next = scoreboard;
    if (xfer) begin
      scoreboard_next[xfer_addr] = 1'b0;
    end
    if (issue_valid && (issue_addr != XZR)) begin
      scoreboard_next[issue_addr] = 1'b1;
    end
    scoreboard_next[31] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scoreboard <= 32'd0;
    end else begin
      scoreboard <= scoreboard_next;
    end
  end

  always_comb begin
    chk_busy1 = scoreboard[chk_addr1] && !(xfer && (xfer_addr == chk_addr1));
    chk_busy2 = scoreboard[chk_addr2] && !(xfer && (xfer_addr == chk_addr2));
  end

endmodule

// File: doc/regwrite_arbiter.md
REGWRITE_ARBITER -- requirements
Module: regwrite_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: alu_valid  in  1  ALU writeback request.
REQ-004 SHALL have ports: alu_addr  in  5  ALU destination register.
REQ-005 SHALL have ports: alu_data  in  64  ALU result.
REQ-006 SHALL have ports: alu_ready  out  1  ALU request accepted this cycle.
REQ-007 SHALL have ports: mem_valid/mem_addr/mem_data/mem_ready  in/in/in/out  1/5/64/1  load writeback, same meanings as ALU set.
REQ-008 SHALL have ports: issue_valid  in  1, issue_addr  in  5  instruction issued, marks destination pending.
REQ-009 SHALL have ports: chk_addr1, chk_addr2  in  5  source registers under test.
REQ-010 SHALL have ports: chk_busy1, chk_busy2  out  1  source register has a pending write.
REQ-011 SHALL have ports: rf_wr_en  out  1, rf_wr_addr  out  5, rf_wr_data  out  64  registered drive of the regfile write port.

Function
REQ-012 SHALL transfer a request when valid and ready are both high at a rising edge; at most one transfer per cycle.
REQ-013 SHALL compute ready combinationally: mem_ready = 1 unless aging override is active; alu_ready = !mem_valid or aging override active.
REQ-014 SHALL, with no override, give mem priority over alu when both are valid.
REQ-015 SHALL register the winner: rf_wr_en/addr/data reflect a transfer at edge N for the whole of cycle N+1 (latency 1); rf_wr_en = 0 in cycles with no prior transfer.
REQ-016 SHALL accept requests to register 31 (XZR) normally but drive rf_wr_en = 0 for them; rf_wr_addr/data still update.
REQ-017 SHALL hold a 32-bit scoreboard: issue_valid sets bit issue_addr; a transfer clears bit of the transferred addr at the same edge.
REQ-018 SHALL let set win over clear when issue and transfer target the same register at the same edge.
REQ-019 SHALL ignore issue_valid for register 31; bit 31 always reads 0.
REQ-020 SHALL drive chk_busyN = scoreboard[chk_addrN] combinationally, and 0 when the same register is being transferred this cycle (write-through visibility).
REQ-021 SHALL not require requesters to hold valid after a refusal; a dropped request has no side effect.

Reset
REQ-022 SHALL, while reset_n = 0, force rf_wr_en = 0, rf_wr_addr = 0, rf_wr_data = 0, scoreboard = 0, age counter = 0, alu_ready = 0, mem_ready = 0.
REQ-023 SHALL discard any transfer in progress when reset asserts mid-cycle; nothing is written after deassertion until a new transfer.

Configuration
REQ-024 SHALL implement ALU starvation aging under macro REGWR_AGE_EN.
REQ-025 SHALL, with REGWR_AGE_EN defined, keep a 2-bit age counter: increments (saturating at 3) each edge alu_valid is high and alu is not granted; clears on ALU transfer or alu_valid low.
REQ-026 SHALL, with REGWR_AGE_EN defined, activate override when counter = 3 and alu_valid = 1: alu granted, mem_ready = 0 for that cycle.
REQ-027 SHALL, without REGWR_AGE_EN, omit the counter; override is never active (strict mem priority).

Verification
REQ-028 SHALL cover: alu_valid=1, addr 5, data 0xAA, mem idle -> alu_ready=1; next cycle rf_wr_en=1, addr 5, data 0xAA.
REQ-029 SHALL cover: both valid (alu addr 3, mem addr 4) -> mem_ready=1, alu_ready=0; next cycle rf_wr_addr=4.
REQ-030 SHALL cover: REGWR_AGE_EN, both valid continuously 4 cycles -> cycles 1-3 mem wins, cycle 4 alu_ready=1, mem_ready=0; without macro mem wins all 4.
REQ-031 SHALL cover: issue addr 7, later mem writes addr 7 -> chk_busy on 7 is 1 until transfer cycle, 0 in transfer cycle and after; same-edge issue and transfer to 7 -> bit remains 1.
REQ-032 SHALL cover: alu write to addr 31 data 0x1 -> rf_wr_en=0 next cycle; issue to 31 -> chk_busy=0.
REQ-033 SHALL cover: reset_n pulsed low mid-transfer -> all outputs 0 immediately, scoreboard empty, no write after release.
